// File: rtl/key_filter.sv
// key_filter: per-key 2-flop synchronizer plus debounce FSM producing a
// one-cycle press pulse (key_flag) and a debounced level (key_state).
module key_filter #(
    parameter int unsigned KEY_NUM        = 2,
    parameter int unsigned CNT_MAX        = 999_999,
    parameter int unsigned CNT_W          = 20,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_flag,
    output logic [KEY_NUM-1:0] key_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // Idle level of a raw key pin; the synchronizer resets to it.
    localparam logic REL_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(CNT_MAX);

    for (genvar i = 0; i < int'(KEY_NUM); i++) begin : g_key
        logic             sync1;
        logic             sync2;
        logic             pressed;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             flag;
        logic             level;

        // Bring the asynchronous pin into the sys_clk domain.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                sync1 <= REL_LVL;
                sync2 <= REL_LVL;
            end else begin
                sync1 <= key_in[i];
                sync2 <= sync1;
            end
        end

        assign pressed = (sync2 != REL_LVL);

        // Debounce FSM; every exit path clears cnt so it never wraps.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state <= IDLE;
                cnt   <= '0;
                flag  <= 1'b0;
                level <= 1'b0;
            end else begin
                flag <= 1'b0;
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            state <= PRESS_DB;
                            cnt   <= '0;
                        end
                    end
                    PRESS_DB: begin
                        if (!pressed) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LIM) begin
                            state <= HELD;
                            cnt   <= '0;
                            flag  <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!pressed) begin
                            state <= REL_DB;
                            cnt   <= '0;
                        end
                    end
                    REL_DB: begin
                        if (pressed) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_LIM) begin
                            state <= IDLE;
                            cnt   <= '0;
                            level <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        assign key_flag[i]  = flag;
        assign key_state[i] = level;
    end

endmodule
